if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Fetch sequencer for the IF stage. It drives the PC register's write enable and an instruction-memory request/ready handshake, and registers the fetched instruction into the IF/ID boundary. It also handles load-use stalls, taken-branch redirects (including squashing a fetch already in flight) and a fetch timeout. It sits between the PC/next-PC mux, the instruction memory, the hazard unit and the IF/ID register.

Parameters:
XLEN, 32, address/instruction width
NOP_INSTR, 32'h00000013, value driven on instr_out when no valid instruction (addi x0,x0,0)
TIMEOUT, 16, max cycles a request may wait for imem_ready before fetch_err sets (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
pc_number  in  XLEN  current PC register value
is_branch  in  1  taken branch/jump resolved this cycle; next-PC mux selects target
load_use_hazard  in  1  hazard unit stall request
imem_req  out  1  instruction-memory request
imem_addr  out  XLEN  request address
imem_ready  in  1  request accepted; imem_rdata valid in the same cycle
imem_rdata  in  XLEN  fetched instruction
PC_Write  out  1  PC register load enable (combinational from state/inputs)
IF_ID_Write  out  1  IF/ID register update enable (combinational)
IF_flush  out  1  squash IF/ID contents (combinational)
instr_out  out  XLEN  registered instruction to IF/ID
instr_valid  out  1  instr_out holds a real instruction
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, instr_out=NOP_INSTR, instr_valid=0, fetch_err=0, wait counter=0, kill_addr=0, skid buffer=0. While in IDLE, all combinational outputs are 0.
- IDLE: unconditionally moves to FETCH on the next edge (one idle cycle after reset release).
- Accept: the cycle in which imem_req=1 and imem_ready=1. At most one request is ever outstanding.
- FETCH: imem_req=1, imem_addr=pc_number. pc_number is stable because the PC only loads on PC_Write. Resolve each cycle in the following priority order:
  1. accept & is_branch: discard rdata. PC_Write=1, IF_flush=1, IF_ID_Write=1. instr_out<=NOP_INSTR, instr_valid<=0. Stay in FETCH.
  2. accept & load_use_hazard: PC_Write=1. skid<=imem_rdata. IF_ID_Write=0. Go to HOLD.
  3. accept: PC_Write=1, IF_ID_Write=1. instr_out<=imem_rdata, instr_valid<=1. Stay in FETCH.
  4. !accept & is_branch: PC_Write=1, IF_flush=1, IF_ID_Write=1. instr_out<=NOP_INSTR, instr_valid<=0. kill_addr<=pc_number. Go to KILL.
  5. !accept: PC_Write=0, IF_ID_Write=0; keep the request asserted. A hazard never aborts a pending request.
- HOLD: imem_req=0, PC_Write=0.
  - is_branch: IF_flush=1, IF_ID_Write=1; drop skid; instr_out<=NOP_INSTR, instr_valid<=0; PC_Write=0 (the target was loaded by the branch cycle's mux). Go to FETCH.
  - Else if !load_use_hazard: IF_ID_Write=1; instr_out<=skid, instr_valid<=1. Go to FETCH.
  - Else: hold all registers.
- KILL: imem_req=1, imem_addr=kill_addr (the squashed request is completed, not withdrawn). On accept, discard rdata and go to FETCH. is_branch in KILL is ignored (pipeline already flushed). PC_Write=0.
- Timeout: the wait counter increments each cycle imem_req=1 & !imem_ready, and clears on accept or on leaving FETCH/KILL. When the counter reaches TIMEOUT-1 with no accept, fetch_err<=1 (sticky until reset). The request continues.
- Reset mid-request: the FSM returns to IDLE, and the outstanding memory transaction is abandoned without handshake.
- Throughput: with imem_ready tied high, one instruction per cycle after the IDLE cycle; instr_out lags pc_number by one cycle.

Test Plan:
- Reset then zero-wait memory: rst=0 for 3 cycles, then 1; imem_ready=1, PC sequence 0,4,8 -> imem_req high from cycle 2; instr_out = rdata for PC 0, then 4, then 8 on consecutive cycles; instr_valid=1; PC_Write=1 every FETCH cycle.
- Wait states: imem_ready low for 3 cycles at PC=0x10 -> imem_addr held at 0x10, PC_Write=0 for 3 cycles, single PC_Write on the 4th cycle; instr_out updates once.
- Load-use stall: accept at PC=0x20 with load_use_hazard=1 for 2 cycles -> state HOLD; imem_req=0, IF_ID_Write=0 for 2 cycles; then instr_out = rdata@0x20, instr_valid=1, fetch resumes at 0x24.
- Branch during outstanding fetch: request at 0x30 pending, is_branch=1 with target 0x100 -> IF_flush=1, PC_Write=1, instr_valid=0; imem_addr stays 0x30 until ready; that rdata is discarded; next request at 0x100.
- Branch with accept plus simultaneous hazard: accept, is_branch=1, load_use_hazard=1 in the same cycle -> branch wins: flush, no HOLD, next fetch at target.
- Timeout: imem_ready low for TIMEOUT=16 cycles -> fetch_err=1 in the 16th waiting cycle and stays 1 after the accept; it clears only on rst=0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer: PC enable, imem handshake, IF/ID register
module if_fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int              TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_number,
  input  logic            is_branch,
  input  logic            load_use_hazard,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            PC_Write,
  output logic            IF_ID_Write,
  output logic            IF_flush,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid,
  output logic            fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_KILL} state_t;

  // Saturation point of the wait counter; fetch_err is raised as the counter lands on it.
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;
  logic [7:0]      wait_cnt;
  logic [XLEN-1:0] kill_addr;
  logic [XLEN-1:0] skid;
  logic            accept;

  assign accept = imem_req & imem_ready;

  // Next-state and handshake/enable decode; defaults keep IDLE fully quiet.
  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    imem_addr   = '0;
    PC_Write    = 1'b0;
    IF_ID_Write = 1'b0;
    IF_flush    = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_number;
        if (imem_ready) begin
          PC_Write = 1'b1;
          if (is_branch) begin
            IF_flush    = 1'b1;
            IF_ID_Write = 1'b1;
          end else if (load_use_hazard) begin
            state_nx = S_HOLD;
          end else begin
            IF_ID_Write = 1'b1;
          end
        end else if (is_branch) begin
          // The in-flight request cannot be withdrawn, so it is completed later from KILL.
          PC_Write    = 1'b1;
          IF_flush    = 1'b1;
          IF_ID_Write = 1'b1;
          state_nx    = S_KILL;
        end
      end
      S_HOLD: begin
        if (is_branch) begin
          IF_flush    = 1'b1;
          IF_ID_Write = 1'b1;
          state_nx    = S_FETCH;
        end else if (!load_use_hazard) begin
          IF_ID_Write = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      S_KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr;
        if (imem_ready) state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register plus IF/ID, skid, kill address and timeout bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
      kill_addr   <= '0;
      skid        <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && accept && !is_branch && load_use_hazard) skid <= imem_rdata;
      if (state == S_HOLD && is_branch) skid <= '0;
      if (state == S_FETCH && !accept && is_branch) kill_addr <= pc_number;
      if (IF_ID_Write) begin
        if (IF_flush) begin
          instr_out   <= NOP_INSTR;
          instr_valid <= 1'b0;
        end else if (state == S_HOLD) begin
          instr_out   <= skid;
          instr_valid <= 1'b1;
        end else begin
          instr_out   <= imem_rdata;
          instr_valid <= 1'b1;
        end
      end
      if (imem_req && !imem_ready) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt >= CNT_MAX - 8'd1) fetch_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed and randomized checks of if_fetch_ctrl
module tb_if_fetch_ctrl;
  localparam int          XLEN    = 32;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam int          TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_number = '0;
  logic        is_branch = 1'b0;
  logic        load_use_hazard = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        PC_Write, IF_ID_Write, IF_flush;
  logic [31:0] instr_out;
  logic        instr_valid, fetch_err;

  int checks = 0;
  int failures = 0;

  if_fetch_ctrl #(.XLEN(XLEN), .NOP_INSTR(NOP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc_number(pc_number), .is_branch(is_branch),
    .load_use_hazard(load_use_hazard), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_Write(PC_Write),
    .IF_ID_Write(IF_ID_Write), .IF_flush(IF_flush), .instr_out(instr_out),
    .instr_valid(instr_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    is_branch = 0; load_use_hazard = 0; imem_ready = 0; imem_rdata = '0;
  endtask

  // Leaves the DUT in its first fetch cycle, inputs quiet.
  task automatic do_reset();
    quiet_inputs();
    rst = 0; tick(); tick();
    rst = 1; tick();
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 0; tick(); tick(); tick();
    checks++; if (instr_out !== NOP) begin failures++; $display("FAIL reset_instr_out act=%h exp=%h", instr_out, NOP); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%b exp=0", instr_valid); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err act=%b exp=0", fetch_err); end
    checks++; if ({imem_req, PC_Write, IF_ID_Write, IF_flush} !== 4'b0) begin failures++; $display("FAIL reset_comb act=%b exp=0000", {imem_req, PC_Write, IF_ID_Write, IF_flush}); end
    rst = 1; imem_ready = 1; is_branch = 1; #1;
    checks++; if ({imem_req, PC_Write, IF_ID_Write, IF_flush} !== 4'b0) begin failures++; $display("FAIL idle_comb act=%b exp=0000", {imem_req, PC_Write, IF_ID_Write, IF_flush}); end
    quiet_inputs(); tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req act=%b exp=1", imem_req); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] d;
    do_reset();
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      pc_number = 32'(4 * i); d = 32'hA000_0000 + pc_number; imem_rdata = d; #1;
      checks++; if (imem_addr !== pc_number || imem_req !== 1'b1) begin failures++; $display("FAIL zw_addr act=%h exp=%h", imem_addr, pc_number); end
      checks++; if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b1) begin failures++; $display("FAIL zw_enables act=%b%b exp=11", PC_Write, IF_ID_Write); end
      tick();
      checks++; if (instr_out !== d || instr_valid !== 1'b1) begin failures++; $display("FAIL zw_instr act=%h/%b exp=%h/1", instr_out, instr_valid, d); end
    end
    quiet_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    pc_number = 32'h10; imem_ready = 0; imem_rdata = 32'hDEAD_0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_addr !== 32'h10 || PC_Write !== 1'b0) begin failures++; $display("FAIL ws_wait addr=%h pcw=%b exp=00000010/0", imem_addr, PC_Write); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ws_novalid act=%b exp=0", instr_valid); end
    end
    imem_ready = 1; imem_rdata = 32'hBEEF_0010; #1;
    checks++; if (PC_Write !== 1'b1) begin failures++; $display("FAIL ws_pcw act=%b exp=1", PC_Write); end
    tick();
    checks++; if (instr_out !== 32'hBEEF_0010 || instr_valid !== 1'b1) begin failures++; $display("FAIL ws_instr act=%h exp=beef0010", instr_out); end
    quiet_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    pc_number = 32'h20; imem_ready = 1; load_use_hazard = 1; imem_rdata = 32'h1234_5678; #1;
    checks++; if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b0) begin failures++; $display("FAIL lu_accept act=%b%b exp=10", PC_Write, IF_ID_Write); end
    tick();
    pc_number = 32'h24; imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({imem_req, IF_ID_Write, PC_Write} !== 3'b000) begin failures++; $display("FAIL lu_hold act=%b exp=000", {imem_req, IF_ID_Write, PC_Write}); end
      tick();
    end
    load_use_hazard = 0; #1;
    checks++; if (IF_ID_Write !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL lu_release act=%b%b exp=10", IF_ID_Write, imem_req); end
    tick();
    checks++; if (instr_out !== 32'h1234_5678 || instr_valid !== 1'b1) begin failures++; $display("FAIL lu_instr act=%h exp=12345678", instr_out); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin failures++; $display("FAIL lu_resume act=%h exp=00000024", imem_addr); end
    quiet_inputs();
  endtask

  task automatic test_branch_inflight();
    do_reset();
    pc_number = 32'h30; imem_ready = 0; is_branch = 1; #1;
    checks++; if ({IF_flush, PC_Write, IF_ID_Write} !== 3'b111) begin failures++; $display("FAIL bi_flush act=%b exp=111", {IF_flush, PC_Write, IF_ID_Write}); end
    tick();
    checks++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin failures++; $display("FAIL bi_nop act=%h exp=%h", instr_out, NOP); end
    pc_number = 32'h100;
    for (int i = 0; i < 2; i++) begin
      is_branch = (i == 0); #1;
      checks++; if (imem_addr !== 32'h30 || {imem_req, PC_Write, IF_flush} !== 3'b100) begin failures++; $display("FAIL bi_kill addr=%h ctl=%b exp=00000030/100", imem_addr, {imem_req, PC_Write, IF_flush}); end
      tick();
    end
    is_branch = 0; imem_ready = 1; imem_rdata = 32'hBAD0_0030; #1;
    checks++; if (PC_Write !== 1'b0 || IF_ID_Write !== 1'b0) begin failures++; $display("FAIL bi_discard act=%b%b exp=00", PC_Write, IF_ID_Write); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bi_dropped act=%b exp=0", instr_valid); end
    imem_rdata = 32'h600D_0100; #1;
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL bi_target act=%h exp=00000100", imem_addr); end
    tick();
    checks++; if (instr_out !== 32'h600D_0100) begin failures++; $display("FAIL bi_instr act=%h exp=600d0100", instr_out); end
    quiet_inputs();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    pc_number = 32'h40; imem_ready = 1; imem_rdata = 32'h4040_4040; tick();
    pc_number = 32'h44; is_branch = 1; load_use_hazard = 1; imem_rdata = 32'h4444_4444; #1;
    checks++; if ({IF_flush, PC_Write, IF_ID_Write} !== 3'b111) begin failures++; $display("FAIL bh_flush act=%b exp=111", {IF_flush, PC_Write, IF_ID_Write}); end
    tick();
    checks++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin failures++; $display("FAIL bh_nop act=%h/%b exp=%h/0", instr_out, instr_valid, NOP); end
    pc_number = 32'h200; is_branch = 0; load_use_hazard = 0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL bh_target act=%b/%h exp=1/00000200", imem_req, imem_addr); end
    quiet_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    pc_number = 32'h50; imem_ready = 0;
    for (int w = 1; w <= TIMEOUT + 2; w++) begin
      #1;
      checks++; if (fetch_err !== (w >= TIMEOUT)) begin failures++; $display("FAIL to_wait%0d act=%b exp=%b", w, fetch_err, (w >= TIMEOUT)); end
      tick();
    end
    imem_ready = 1; tick();
    checks++; if (fetch_err !== 1'b1 || instr_valid !== 1'b1) begin failures++; $display("FAIL to_sticky act=%b exp=1", fetch_err); end
    quiet_inputs(); rst = 0; tick(); rst = 1;
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL to_clear act=%b exp=0", fetch_err); end
  endtask

  // Reference model: the pipeline is "running", possibly "holding" a skidded word or
  // "killing" a squashed request; PC register modelled as m_pc.
  task automatic test_random();
    bit m_run, m_hold, m_kill, m_err;
    logic [31:0] m_kaddr, m_skid, m_iout, m_pc, tgt;
    bit m_valid, e_req, e_pcw, e_ifid, e_flush, br, hz, rdy;
    logic [31:0] rd;
    int m_waits;
    do_reset();
    m_run = 1; m_hold = 0; m_kill = 0; m_err = 0; m_kaddr = 0; m_skid = 0;
    m_iout = NOP; m_valid = 0; m_pc = 0; m_waits = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      rdy = ($urandom_range(0, 9) < 6); br = ($urandom_range(0, 4) == 0);
      hz = ($urandom_range(0, 3) == 0); rd = $urandom; tgt = $urandom & 32'hFFFF_FFFC;
      imem_ready = rdy; is_branch = br; load_use_hazard = hz; imem_rdata = rd; pc_number = m_pc;
      e_req = m_run && !m_hold;
      e_pcw = 0; e_ifid = 0; e_flush = 0;
      if (m_run && !m_hold && !m_kill) begin
        if (rdy) begin e_pcw = 1; e_flush = br; e_ifid = br || !hz; end
        else if (br) begin e_pcw = 1; e_flush = 1; e_ifid = 1; end
      end else if (m_hold) begin
        e_flush = br; e_ifid = br || !hz;
      end
      #1;
      checks++; if ({imem_req, PC_Write, IF_ID_Write, IF_flush} !== {e_req, e_pcw, e_ifid, e_flush}) begin failures++; $display("FAIL rnd_ctl c=%0d act=%b exp=%b", c, {imem_req, PC_Write, IF_ID_Write, IF_flush}, {e_req, e_pcw, e_ifid, e_flush}); end
      if (e_req) begin
        checks++; if (imem_addr !== (m_kill ? m_kaddr : m_pc)) begin failures++; $display("FAIL rnd_addr c=%0d act=%h exp=%h", c, imem_addr, (m_kill ? m_kaddr : m_pc)); end
      end
      tick();
      if (!rst) begin
        m_run = 0; m_hold = 0; m_kill = 0; m_err = 0; m_kaddr = 0; m_skid = 0;
        m_iout = NOP; m_valid = 0; m_pc = 0; m_waits = 0;
      end else begin
        if (e_req && !rdy) begin m_waits++; if (m_waits >= TIMEOUT - 1) m_err = 1; end
        else m_waits = 0;
        if (!m_run) m_run = 1;
        else if (m_kill) begin if (rdy) m_kill = 0; end
        else if (m_hold) begin
          if (br) begin m_iout = NOP; m_valid = 0; m_hold = 0; m_skid = 0; end
          else if (!hz) begin m_iout = m_skid; m_valid = 1; m_hold = 0; end
        end else if (rdy) begin
          if (br) begin m_iout = NOP; m_valid = 0; end
          else if (hz) begin m_skid = rd; m_hold = 1; end
          else begin m_iout = rd; m_valid = 1; end
        end else if (br) begin
          m_iout = NOP; m_valid = 0; m_kill = 1; m_kaddr = m_pc;
        end
        if (e_pcw) m_pc = br ? tgt : m_pc + 32'd4;
      end
      checks++; if ({instr_out, instr_valid, fetch_err} !== {m_iout, m_valid, m_err}) begin failures++; $display("FAIL rnd_reg c=%0d act=%h/%b/%b exp=%h/%b/%b", c, instr_out, instr_valid, fetch_err, m_iout, m_valid, m_err); end
    end
    rst = 1; quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_load_use();
    test_branch_inflight();
    test_branch_hazard();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
